// File: rtl/ddr3_app_pkg.sv
// Shared types and constants for the DDR3 user-interface initiator.
package ddr3_app_pkg;

  localparam logic [2:0] CMD_WR = 3'd0;
  localparam logic [2:0] CMD_RD = 3'd1;

  localparam int APP_DATA_W = 128;
  localparam int APP_MASK_W = 16;
  localparam int APP_ADDR_W = 28;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_WR,
    S_RCMD,
    S_RWAIT,
    S_RESP
  } state_t;

endpackage

// File: rtl/ddr3_app_master.sv
// Single-outstanding 128-bit read/write initiator for the DDR3 application
// interface, with calibration gating and a bounded read-data wait.
module ddr3_app_master
  import ddr3_app_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [31:0]           req_addr,
  input  logic [APP_DATA_W-1:0] req_wdata,
  input  logic [APP_MASK_W-1:0] req_wstrb,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [APP_DATA_W-1:0] resp_rdata,
  output logic                  resp_err,
  output logic [2:0]            cmd,
  output logic                  cmd_en,
  input  logic                  cmd_ready,
  output logic [APP_ADDR_W-1:0] addr,
  output logic [5:0]            app_burst_number,
  output logic [APP_DATA_W-1:0] wr_data,
  output logic                  wr_data_en,
  output logic                  wr_data_end,
  output logic [APP_MASK_W-1:0] wr_data_mask,
  input  logic                  wr_data_rdy,
  input  logic [APP_DATA_W-1:0] rd_data,
  input  logic                  rd_data_valid,
  input  logic                  rd_data_end,
  input  logic                  init_calib_complete,
  output state_t                dbg_state
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  // Handshakes: a transfer happens on every clock edge where the valid-side
  // strobe (req_valid, cmd_en, wr_data_en, resp_valid) and the matching
  // ready (req_ready, cmd_ready, wr_data_rdy, resp_ready) are both high.
  state_t                  state_q, state_d;
  logic                    cmd_done_q, cmd_done_d;
  logic                    wr_done_q, wr_done_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [APP_DATA_W-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic                    capture;
  logic [APP_ADDR_W-1:0]   addr_q;
  logic [APP_DATA_W-1:0]   wdata_q;
  logic [APP_MASK_W-1:0]   mask_q;
  logic [2:0]              cmd_q;
  logic                    unused_ok;

  assign unused_ok = ^{rd_data_end, req_addr[3:0]};

  always_comb begin
    state_d    = state_q;
    cmd_done_d = cmd_done_q;
    wr_done_d  = wr_done_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    capture    = 1'b0;
    case (state_q)
      S_INIT: if (init_calib_complete) state_d = S_IDLE;
      S_IDLE: begin
        if (req_valid) begin
          capture    = 1'b1;
          cmd_done_d = 1'b0;
          wr_done_d  = 1'b0;
          state_d    = req_we ? S_WR : S_RCMD;
        end
      end
      S_WR: begin
        // Command and data channels complete independently, in either order.
        if ((cmd_done_q || cmd_ready) && (wr_done_q || wr_data_rdy)) begin
          state_d    = S_RESP;
          rdata_d    = '0;
          err_d      = 1'b0;
          cmd_done_d = 1'b0;
          wr_done_d  = 1'b0;
        end else begin
          cmd_done_d = cmd_done_q || cmd_ready;
          wr_done_d  = wr_done_q || wr_data_rdy;
        end
      end
      S_RCMD: begin
        if (cmd_ready) begin
          state_d = S_RWAIT;
          cnt_d   = '0;
        end
      end
      S_RWAIT: begin
        // Data arriving on the last allowed cycle beats the timeout.
        if (rd_data_valid) begin
          rdata_d = rd_data;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: if (resp_ready) state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_INIT;
      cmd_done_q <= 1'b0;
      wr_done_q  <= 1'b0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mask_q     <= '1;
      cmd_q      <= CMD_WR;
    end else begin
      state_q    <= state_d;
      cmd_done_q <= cmd_done_d;
      wr_done_q  <= wr_done_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      if (capture) begin
        addr_q  <= req_addr[31:4];
        wdata_q <= req_wdata;
        mask_q  <= ~req_wstrb;
        cmd_q   <= req_we ? CMD_WR : CMD_RD;
      end
    end
  end

  assign req_ready        = (state_q == S_IDLE);
  assign cmd_en           = ((state_q == S_WR) && !cmd_done_q) || (state_q == S_RCMD);
  assign wr_data_en       = (state_q == S_WR) && !wr_done_q;
  assign wr_data_end      = wr_data_en;
  assign resp_valid       = (state_q == S_RESP);
  assign resp_rdata       = rdata_q;
  assign resp_err         = err_q;
  assign cmd              = cmd_q;
  assign addr             = addr_q;
  assign wr_data          = wdata_q;
  assign wr_data_mask     = mask_q;
  assign app_burst_number = 6'd0;
  assign dbg_state        = state_q;

endmodule
